fifo_sync_param: RTL

- Parametrised synchronous FIFO. Next-generation buffer for the UART TX and RX paths.
- Configurable data width and depth. Uses all DEPTH entries, unlike the previous 8x8 FIFO, which lost one slot.
- Adds: occupancy count, almost-full/almost-empty thresholds, a read-valid strobe, synchronous flush, sticky overflow/underflow error flags, and defined simultaneous read/write at the full and empty boundaries.

---
 rtl/fifo_sync_param.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO for the UART TX/RX paths. Tracks occupancy
// with a separate counter, so all DEPTH entries are usable.
module fifo_sync_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         data_out,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C    = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_THRESH  = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_THRESH  = (AW+1)'(AE_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] dataOut_q, dataOut_d;
    logic             rdValid_q, rdValid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic isEmpty;
    logic isFull;
    logic wrAcc;
    logic rdAcc;

    assign isEmpty = (count_q == '0);
    assign isFull  = (count_q == DEPTH_C);

    // A write into a full FIFO is allowed when a read frees a slot in the same
    // cycle; reads never fall through from a same-cycle write. Flush wins over both.
    assign rdAcc = rd_en && !isEmpty && !flush;
    assign wrAcc = wr_en && (!isFull || rd_en) && !flush;

    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        dataOut_d   = dataOut_q;
        rdValid_d   = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            wrPtr_d     = '0;
            rdPtr_d     = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wrAcc) begin
                wrPtr_d = wrPtr_q + AW'(1);
            end
            if (rdAcc) begin
                rdPtr_d   = rdPtr_q + AW'(1);
                dataOut_d = mem_q[rdPtr_q];
                rdValid_d = 1'b1;
            end
            case ({wrAcc, rdAcc})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
            if (wr_en && !wrAcc) begin
                overflow_d = 1'b1;
            end
            if (rd_en && !rdAcc) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            dataOut_q   <= '0;
            rdValid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            dataOut_q   <= dataOut_d;
            rdValid_q   <= rdValid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage has no reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clock) begin
        if (reset && wrAcc) begin
            mem_q[wrPtr_q] <= data_in;
        end
    end

    assign data_out     = dataOut_q;
    assign rd_valid     = rdValid_q;
    assign empty        = isEmpty;
    assign full         = isFull;
    assign almost_empty = (count_q <= AE_THRESH);
    assign almost_full  = (count_q >= AF_THRESH);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
